// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares one single-ported, 1-cycle-latency data memory between
//               the CPU memory stage (port C) and a DMA/peripheral master
//               (port D). At most one access is issued per cycle. Port C wins
//               by default. Port D wins when C is idle, or once it has been
//               blocked MAX_WAIT times.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata    CPU access request (held while cpu_stall=1)
//   cpu_rdata, cpu_stall     CPU read data (valid when stall falls), stall
//   dma_req/we/addr/wdata    DMA request (held stable until dma_gnt)
//   dma_gnt                  DMA access issued this cycle (pulse)
//   dma_rvalid, dma_rdata    DMA read data return (pulse)
//   mem_re/we/addr/wdata     memory command, word addressed
//   mem_rdata                memory read data, valid 1 cycle after mem_re
// ============================================================================
module dmem_arbiter #(
    parameter int MEM_AW   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [31:0]       dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [31:0]       dma_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_C = 2'd1,
        RD_D = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] wait_cnt;

    logic idle;
    logic d_wins;
    logic issue_c;
    logic issue_d;

    // Byte-lane bits and bits above the memory window are not used.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[1:0], cpu_addr[31:MEM_AW+2],
                                dma_addr[1:0], dma_addr[31:MEM_AW+2]};

    // Issue is only possible in IDLE and never while reset is held.
    assign idle    = (state == IDLE) && !rst;
    assign d_wins  = dma_req && ((wait_cnt >= 4'(MAX_WAIT)) || !cpu_req);
    assign issue_d = idle && d_wins;
    assign issue_c = idle && cpu_req && !d_wins;

    // Memory command: the winner's fields are steered onto the bus; enables
    // are only raised in an actual issue cycle.
    assign mem_re    = (issue_c && !cpu_we) || (issue_d && !dma_we);
    assign mem_we    = (issue_c &&  cpu_we) || (issue_d &&  dma_we);
    assign mem_addr  = d_wins ? dma_addr[MEM_AW+1:2] : cpu_addr[MEM_AW+1:2];
    assign mem_wdata = d_wins ? dma_wdata : cpu_wdata;

    // Read data is a straight passthrough; the qualifiers say who owns it.
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;
    assign dma_gnt    = issue_d;
    assign dma_rvalid = (state == RD_D) && !rst;

    // Stall: a C write retires in its issue cycle, a C read releases in RD_C,
    // and a C request that meets RD_D or loses arbitration must wait.
    always_comb begin
        cpu_stall = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    cpu_stall = cpu_req && (d_wins || !cpu_we);
                RD_C:    cpu_stall = 1'b0;
                RD_D:    cpu_stall = cpu_req;
                default: cpu_stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue_c && !cpu_we) begin
                        state <= RD_C;
                    end else if (issue_d && !dma_we) begin
                        state <= RD_D;
                    end
                end
                RD_C:    state <= IDLE;
                RD_D:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // Count how often a pending D request lost to C; saturate at 15.
            if (issue_d) begin
                wait_cnt <= 4'd0;
            end else if (issue_c && dma_req && (wait_cnt != 4'd15)) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed, table-driven bench for dmem_arbiter. Each record
//               holds one cycle of inputs and the outputs expected before the
//               next rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
    logic [31:0] cpu_rdata, dma_rdata, mem_wdata;
    logic        cpu_stall, dma_gnt, dma_rvalid, mem_re, mem_we;
    logic [15:0] mem_addr;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_AW(16), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .dma_rdata(dma_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [79:0] nm;
        logic        rst, creq, cwe;
        logic [31:0] caddr, cwd;
        logic        dreq, dwe;
        logic [31:0] daddr, dwd, mrd;
        logic        e_re, e_we;
        logic [15:0] e_addr;
        logic [31:0] e_wd;
        logic        e_stall, e_gnt, e_rv, chk_crd;
        logic [31:0] e_rd;
    } vec_t;

    function automatic vec_t mk(
        input logic [79:0] nm, input logic r, input logic creq, input logic cwe,
        input logic [31:0] caddr, input logic [31:0] cwd,
        input logic dreq, input logic dwe, input logic [31:0] daddr,
        input logic [31:0] dwd, input logic [31:0] mrd,
        input logic e_re, input logic e_we, input logic [15:0] e_addr,
        input logic [31:0] e_wd, input logic e_stall, input logic e_gnt,
        input logic e_rv, input logic chk_crd, input logic [31:0] e_rd);
        vec_t v;
        v.nm = nm; v.rst = r; v.creq = creq; v.cwe = cwe; v.caddr = caddr;
        v.cwd = cwd; v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
        v.mrd = mrd; v.e_re = e_re; v.e_we = e_we; v.e_addr = e_addr;
        v.e_wd = e_wd; v.e_stall = e_stall; v.e_gnt = e_gnt; v.e_rv = e_rv;
        v.chk_crd = chk_crd; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input logic [79:0] nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %0s.%0s: got %h expected %h", nm, fld, act, exp);
    endtask

    // Drive one cycle at the falling edge, check just after, state advances
    // on the following rising edge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.rst; cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr;
        cpu_wdata = v.cwd; dma_req = v.dreq; dma_we = v.dwe;
        dma_addr = v.daddr; dma_wdata = v.dwd; mem_rdata = v.mrd;
        #1;
        chk(v.nm, "mem_re",     {31'd0, mem_re},     {31'd0, v.e_re});
        chk(v.nm, "mem_we",     {31'd0, mem_we},     {31'd0, v.e_we});
        chk(v.nm, "cpu_stall",  {31'd0, cpu_stall},  {31'd0, v.e_stall});
        chk(v.nm, "dma_gnt",    {31'd0, dma_gnt},    {31'd0, v.e_gnt});
        chk(v.nm, "dma_rvalid", {31'd0, dma_rvalid}, {31'd0, v.e_rv});
        if (v.e_re || v.e_we) chk(v.nm, "mem_addr", {16'd0, mem_addr}, {16'd0, v.e_addr});
        if (v.e_we)    chk(v.nm, "mem_wdata", mem_wdata, v.e_wd);
        if (v.chk_crd) chk(v.nm, "cpu_rdata", cpu_rdata, v.e_rd);
        if (v.e_rv)    chk(v.nm, "dma_rdata", dma_rdata, v.e_rd);
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);

        //             name        rst req we addr          wdata         dreq dwe daddr    dwdata   mrd           re we addr     wd            stl gnt rv crd rd
        tbl.push_back(mk("rst",      1, 1, 0, 32'h10,       0,             1, 0, 32'h40,  0,       0,            0, 0, 16'h0,    0,            0, 0, 0, 0, 0));
        tbl.push_back(mk("idle",     0, 0, 0, 0,            0,             0, 0, 0,       0,       0,            0, 0, 16'h0,    0,            0, 0, 0, 0, 0));
        tbl.push_back(mk("c_rd0",    0, 1, 0, 32'h10,       0,             0, 0, 0,       0,       0,            1, 0, 16'h4,    0,            1, 0, 0, 0, 0));
        tbl.push_back(mk("c_rd1",    0, 1, 0, 32'h10,       0,             0, 0, 0,       0,       32'hDEADBEEF, 0, 0, 16'h0,    0,            0, 0, 0, 1, 32'hDEADBEEF));
        tbl.push_back(mk("c_wr",     0, 1, 1, 32'h20,       32'h1234,      0, 0, 0,       0,       0,            0, 1, 16'h8,    32'h1234,     0, 0, 0, 0, 0));
        tbl.push_back(mk("d_rd0",    0, 0, 0, 0,            0,             1, 0, 32'h40,  0,       0,            1, 0, 16'h10,   0,            0, 1, 0, 0, 0));
        tbl.push_back(mk("d_rd1",    0, 0, 0, 0,            0,             0, 0, 0,       0,       32'hCAFEF00D, 0, 0, 16'h0,    0,            0, 0, 1, 0, 32'hCAFEF00D));
        tbl.push_back(mk("d_wr",     0, 0, 0, 0,            0,             1, 1, 32'h44,  32'h55AA,0,            0, 1, 16'h11,   32'h55AA,     0, 1, 0, 0, 0));
        tbl.push_back(mk("d_wr_nrv", 0, 0, 0, 0,            0,             0, 0, 0,       0,       32'h99,       0, 0, 16'h0,    0,            0, 0, 0, 0, 0));
        tbl.push_back(mk("c_wr_top", 0, 1, 1, 32'h0003FFFF, 32'hA5A5A5A5,  0, 0, 0,       0,       0,            0, 1, 16'hFFFF, 32'hA5A5A5A5, 0, 0, 0, 0, 0));
        tbl.push_back(mk("c_wr_wrp", 0, 1, 1, 32'h00040013, 32'h1,         0, 0, 0,       0,       0,            0, 1, 16'h0004, 32'h1,        0, 0, 0, 0, 0));
        // C and D reads together: C first, D next idle, rvalid 3 cycles on
        tbl.push_back(mk("both0",    0, 1, 0, 32'h100,      0,             1, 0, 32'h200, 0,       0,            1, 0, 16'h40,   0,            1, 0, 0, 0, 0));
        tbl.push_back(mk("both1",    0, 1, 0, 32'h100,      0,             1, 0, 32'h200, 0,       32'h11112222, 0, 0, 16'h0,    0,            0, 0, 0, 1, 32'h11112222));
        tbl.push_back(mk("both2",    0, 0, 0, 0,            0,             1, 0, 32'h200, 0,       0,            1, 0, 16'h80,   0,            0, 1, 0, 0, 0));
        tbl.push_back(mk("both3",    0, 0, 0, 0,            0,             0, 0, 0,       0,       32'h33334444, 0, 0, 16'h0,    0,            0, 0, 1, 0, 32'h33334444));
        // C read arriving during RD_D stalls, then issues back-to-back
        tbl.push_back(mk("dd_rd0",   0, 0, 0, 0,            0,             1, 0, 32'h8,   0,       0,            1, 0, 16'h2,    0,            0, 1, 0, 0, 0));
        tbl.push_back(mk("dd_rd1",   0, 1, 0, 32'hC,        0,             0, 0, 0,       0,       32'h77,       0, 0, 16'h0,    0,            1, 0, 1, 0, 32'h77));
        tbl.push_back(mk("dd_c0",    0, 1, 0, 32'hC,        0,             0, 0, 0,       0,       0,            1, 0, 16'h3,    0,            1, 0, 0, 0, 0));
        tbl.push_back(mk("dd_c1",    0, 1, 0, 32'hC,        0,             0, 0, 0,       0,       32'h88,       0, 0, 16'h0,    0,            0, 0, 0, 1, 32'h88));
        // Reset while in RD_D drops the read; fresh C read afterwards
        tbl.push_back(mk("rs_d0",    0, 0, 0, 0,            0,             1, 0, 32'h50,  0,       0,            1, 0, 16'h14,   0,            0, 1, 0, 0, 0));
        tbl.push_back(mk("rs_rst",   1, 1, 0, 32'h60,       0,             1, 0, 32'h50,  0,       32'hBAD,      0, 0, 16'h0,    0,            0, 0, 0, 0, 0));
        tbl.push_back(mk("rs_idle",  0, 0, 0, 0,            0,             0, 0, 0,       0,       32'hBAD,      0, 0, 16'h0,    0,            0, 0, 0, 0, 0));
        tbl.push_back(mk("rs_c0",    0, 1, 0, 32'h60,       0,             0, 0, 0,       0,       0,            1, 0, 16'h18,   0,            1, 0, 0, 0, 0));
        tbl.push_back(mk("rs_c1",    0, 1, 0, 32'h60,       0,             0, 0, 0,       0,       32'h600D,     0, 0, 16'h0,    0,            0, 0, 0, 1, 32'h600D));
        // Contended C writes push wait_cnt to 3, D withdraws: no access
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk("wd_c",  0, 1, 1, 32'h0,        32'h5,         1, 0, 32'h300, 0,       0,            0, 1, 16'h0,    32'h5,        0, 0, 0, 0, 0));
        tbl.push_back(mk("wd_idle",  0, 0, 0, 0,            0,             0, 0, 0,       0,       0,            0, 0, 16'h0,    0,            0, 0, 0, 0, 0));
        // Reset must clear wait_cnt; starvation below depends on it
        tbl.push_back(mk("wd_rst",   1, 0, 0, 0,            0,             0, 0, 0,       0,       0,            0, 0, 16'h0,    0,            0, 0, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // Starvation: continuous C writes with D held. Four C grants, then D
        // wins on the fifth; a second round shows wait_cnt cleared on gnt.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++) begin
                logic [31:0] ca;
                ca = 32'((r * 16 + i) * 4);
                if (i < 4)
                    apply(mk("starv_c", 0, 1, 1, ca, 32'(i), 1, 1, 32'h400, 32'(8'hD0 + r), 0,
                             0, 1, 16'(r * 16 + i), 32'(i), 0, 0, 0, 0, 0));
                else
                    apply(mk("starv_d", 0, 1, 1, ca, 32'(i), 1, 1, 32'h400, 32'(8'hD0 + r), 0,
                             0, 1, 16'h100, 32'(8'hD0 + r), 1, 1, 0, 0, 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
